// File: rtl/spi_flash_pkg.sv
// Shared definitions for the W25Q64 flash front-end: state encoding, opcodes,
// pad defaults and the quad-read latency helper.
package spi_flash_pkg;

    // State set is shared with the init stage; the read engine only uses a subset.
    typedef enum logic [3:0] {
        StIdle,
        StWren,
        StWrsr,
        StRdsr,
        StLatch,
        StCmd,
        StAddr,
        StDummy,
        StData,
        StResp
    } spi_state_e;

    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRSR  = 8'h01;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_QREAD = 8'h6B;

    // Pad patterns, bit order IO3..IO0. IO2/IO3 double as WP#/HOLD# and idle high.
    localparam logic [3:0] IO_IDLE = 4'b1100;
    localparam logic [3:0] OE_IDLE = 4'b1100;
    localparam logic [3:0] OE_CMD  = 4'b1101;
    localparam logic [3:0] OE_DATA = 4'b0000;

    // ACLK edges from the accepting edge until rsp_valid is seen high.
    function automatic int unsigned qread_latency(input int unsigned addr_w,
                                                  input int unsigned dummy);
        return 2 * (8 + addr_w + dummy + 8) + 1;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: one SPI bit spans two ACLK cycles (phase L then phase H).
// Runs only while chip select is asserted and parks low otherwise.
module spi_sclk_gen (
    input  logic clk_i,
    input  logic rst_i,
    input  logic cs_n_i,
    output logic sclk_o,
    output logic bit_end_o
);

    logic ph_q;

    // Toggle phase every cycle while selected; restart in phase L when deselected.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ph_q <= 1'b0;
        end else if (!cs_n_i) begin
            ph_q <= ~ph_q;
        end else begin
            ph_q <= 1'b0;
        end
    end

    assign sclk_o = ph_q;
    // High during phase H: the coming edge ends the bit.
    assign bit_end_o = !cs_n_i && ph_q;

endmodule

// File: rtl/spi_quad_read.sv
// Fast Read Quad Output (0x6B) engine: one little-endian 32-bit word per request.
// DUMMY_CYCLES and CS_HIGH_MIN must be at least 1.
module spi_quad_read
    import spi_flash_pkg::*;
#(
    parameter int unsigned ADDR_W       = 24,
    parameter int unsigned DUMMY_CYCLES = 8,
    parameter int unsigned CS_HIGH_MIN  = 2
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              init_done,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              CS,
    output logic              CLOCK,
    output logic [3:0]        io_out,
    output logic [3:0]        io_oe,
    input  logic [3:0]        io_in
);

    localparam int unsigned SH_W  = 8 + ADDR_W;
    localparam int unsigned GAP_W = $clog2(CS_HIGH_MIN + 1);

    spi_state_e        state_q;
    logic [SH_W-1:0]   sh_q;
    logic [7:0]        cnt_q;
    logic [GAP_W-1:0]  gap_q;
    logic [31:0]       asm_q;
    logic [31:0]       asm_next;
    logic [4:0]        nib_pos;
    logic              bit_end;

    spi_sclk_gen u_sclk (
        .clk_i    (ACLK),
        .rst_i    (ARESET),
        .cs_n_i   (CS),
        .sclk_o   (CLOCK),
        .bit_end_o(bit_end)
    );

    assign req_ready = (state_q == StIdle) && init_done && (gap_q == '0);

    // Merge the incoming nibble: high nibble of byte k first, byte k at [8k+7:8k].
    always_comb begin
        nib_pos = {cnt_q[2:1], ~cnt_q[0], 2'b00};
        asm_next = asm_q;
        asm_next[nib_pos +: 4] = io_in;
    end

    // Transaction FSM with registered pad, handshake and data outputs.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= StIdle;
            CS        <= 1'b1;
            io_out    <= IO_IDLE;
            io_oe     <= OE_IDLE;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            sh_q      <= '0;
            cnt_q     <= '0;
            gap_q     <= GAP_W'(CS_HIGH_MIN);
            asm_q     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (gap_q != '0) begin
                        gap_q <= gap_q - 1'b1;
                    end
                    if (req_valid && req_ready) begin
                        sh_q    <= {OP_QREAD, req_addr};
                        state_q <= StLatch;
                    end
                end
                StLatch: begin
                    CS      <= 1'b0;
                    io_oe   <= OE_CMD;
                    io_out  <= {IO_IDLE[3:1], sh_q[SH_W-1]};
                    cnt_q   <= '0;
                    asm_q   <= '0;
                    state_q <= StCmd;
                end
                StCmd: begin
                    if (bit_end) begin
                        sh_q      <= sh_q << 1;
                        io_out[0] <= sh_q[SH_W-2];
                        if (cnt_q == 8'd7) begin
                            cnt_q   <= '0;
                            state_q <= StAddr;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StAddr: begin
                    if (bit_end) begin
                        if (cnt_q == 8'(ADDR_W - 1)) begin
                            // Release IO0 as the first dummy phase L begins.
                            cnt_q   <= '0;
                            io_oe   <= OE_IDLE;
                            io_out  <= IO_IDLE;
                            state_q <= StDummy;
                        end else begin
                            sh_q      <= sh_q << 1;
                            io_out[0] <= sh_q[SH_W-2];
                            cnt_q     <= cnt_q + 1'b1;
                        end
                    end
                end
                StDummy: begin
                    if (bit_end) begin
                        if (cnt_q == 8'(DUMMY_CYCLES - 1)) begin
                            cnt_q   <= '0;
                            io_oe   <= OE_DATA;
                            state_q <= StData;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StData: begin
                    if (bit_end) begin
                        asm_q <= asm_next;
                        if (cnt_q == 8'd7) begin
                            CS        <= 1'b1;
                            io_oe     <= OE_IDLE;
                            rsp_valid <= 1'b1;
                            rsp_data  <= asm_next;
                            cnt_q     <= '0;
                            state_q   <= StResp;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        gap_q     <= GAP_W'(CS_HIGH_MIN);
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_quad_read.sv
// Bench for spi_quad_read: pin-level W25Q64 quad-read model, a per-cycle
// timeline model of the outputs, and directed literal checks.
module tb_spi_quad_read;

    localparam int CS_HIGH_MIN = 2;

    logic        ACLK;
    logic        ARESET;
    logic        init_done;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        CS;
    logic        CLOCK;
    logic [3:0]  io_out;
    logic [3:0]  io_oe;
    logic [3:0]  io_in;

    spi_quad_read #(
        .ADDR_W      (24),
        .DUMMY_CYCLES(8),
        .CS_HIGH_MIN (CS_HIGH_MIN)
    ) dut (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .init_done(init_done),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .CS       (CS),
        .CLOCK    (CLOCK),
        .io_out   (io_out),
        .io_oe    (io_oe),
        .io_in    (io_in)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic expire(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    // Flash contents: explicit bytes, otherwise a fixed address-derived pattern.
    logic [7:0] mem [int];

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] word_at(input logic [23:0] a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = mem_byte(a + 24'(k));
        return w;
    endfunction

    // Pin-level flash: samples IO0 on SCLK rise, drives the next nibble after SCLK fall.
    bit          fl_active = 0;
    bit          fl_prev_clk = 0;
    int          fl_rises = 0;
    int          fl_total = 0;
    logic [31:0] fl_sh = '0;
    logic [7:0]  fl_cmd = '0;
    logic [23:0] fl_addr = '0;

    always @(negedge ACLK) begin
        int j;
        logic [7:0] byt;
        if (CS !== 1'b0) begin
            if (fl_active) begin
                fl_cmd   = fl_sh[31:24];
                fl_addr  = fl_sh[23:0];
                fl_total = fl_rises;
            end
            fl_active   = 0;
            fl_prev_clk = 0;
        end else begin
            if (!fl_active) begin
                fl_active = 1;
                fl_rises  = 0;
                fl_sh     = '0;
            end
            if (CLOCK && !fl_prev_clk) begin
                if (fl_rises < 32) fl_sh = {fl_sh[30:0], io_out[0]};
                fl_rises++;
            end
            if (!CLOCK && fl_prev_clk && fl_rises >= 40 && fl_rises < 48) begin
                j     = fl_rises - 40;
                byt   = mem_byte(fl_sh[23:0] + 24'(j / 2));
                io_in = (j % 2 == 0) ? byt[7:4] : byt[3:0];
            end
            fl_prev_clk = CLOCK;
        end
    end

    // Timeline model: after an accept at edge 0, bit b drives from edge 2b+1,
    // SCLK high from edge 2b+2, and rsp_valid rises at edge 97.
    bit          m_busy = 0;
    int          m_t = 0;
    int          m_idle = 0;
    logic [31:0] m_word = '0;
    logic [31:0] m_bits = '0;
    logic [31:0] got_q [$];
    logic        e_cs, e_clk, e_rv, e_rr;
    logic [3:0]  e_oe, e_out;
    int          m_b;

    always @(negedge ACLK) begin
        if (ARESET) begin
            check("reset_pins", 32'({CS, CLOCK, io_oe, io_out, rsp_valid, req_ready}),
                  32'({1'b1, 1'b0, 4'b1100, 4'b1100, 1'b0, 1'b0}));
            check("reset_data", rsp_data, 32'h0);
            m_busy = 0;
            m_t    = 0;
            m_idle = 0;
        end else begin
            e_cs  = 1'b1;
            e_clk = 1'b0;
            e_oe  = 4'b1100;
            e_out = 4'b1100;
            e_rv  = 1'b0;
            e_rr  = 1'b0;
            if (!m_busy) begin
                e_rr = init_done && (m_idle >= CS_HIGH_MIN);
            end else if (m_t >= 1 && m_t <= 96) begin
                e_cs  = 1'b0;
                e_clk = (m_t % 2 == 0);
                m_b   = (m_t - 1) / 2;
                if (m_b < 32) begin
                    e_oe  = 4'b1101;
                    e_out = {3'b110, m_bits[31 - m_b]};
                end else if (m_b < 40) begin
                    e_oe = 4'b1100;
                end else begin
                    e_oe = 4'b0000;
                end
            end else if (m_t >= 97) begin
                e_rv = 1'b1;
            end
            check("pins", 32'({CS, CLOCK, io_oe, io_out & e_oe, rsp_valid, req_ready}),
                  32'({e_cs, e_clk, e_oe, e_out & e_oe, e_rv, e_rr}));
            if (e_rv) check("rsp_data", rsp_data, m_word);
            if (rsp_valid && rsp_ready) got_q.push_back(rsp_data);
            if (!m_busy) begin
                if (req_valid && e_rr) begin
                    m_busy = 1;
                    m_t    = 0;
                    m_word = word_at(req_addr);
                    m_bits = {8'h6B, req_addr};
                end else begin
                    m_idle++;
                end
            end else if (m_t >= 97) begin
                if (rsp_ready) begin
                    m_busy = 0;
                    m_idle = 0;
                end
            end else begin
                m_t++;
            end
        end
    end

    // CS-high run length between selected periods.
    int  hi_run = 0;
    int  last_gap = 0;
    int  min_gap = 1000000;
    bit  seen_low = 0;

    always @(negedge ACLK) begin
        if (CS === 1'b1) begin
            hi_run++;
        end else if (CS === 1'b0) begin
            if (seen_low && hi_run > 0) begin
                last_gap = hi_run;
                if (hi_run < min_gap) min_gap = hi_run;
            end
            hi_run   = 0;
            seen_low = 1;
        end
    end

    task automatic wait_accept(output bit ok);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge ACLK);
            if (req_ready) begin
                ok = 1;
                break;
            end
        end
        if (ok) begin
            @(posedge ACLK);
            #1;
        end else begin
            expire("accept");
        end
    endtask

    // One read; drops init_done while busy and optionally stalls rsp_ready.
    task automatic read_word(input logic [23:0] a, input int stall,
                             output logic [31:0] d, output int lat);
        int acc;
        bit ok;
        d   = '0;
        lat = -1;
        req_addr  = a;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        wait_accept(ok);
        req_valid = 1'b0;
        if (!ok) return;
        acc = cyc;
        init_done = 1'b0;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge ACLK);
            if (rsp_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            @(posedge ACLK);
            #1;
            init_done = 1'b1;
            expire("rsp_valid");
            return;
        end
        lat = cyc - acc;
        d   = rsp_data;
        if (stall > 0) begin
            repeat (stall) @(negedge ACLK);
            check("hold_valid", 32'(rsp_valid), 32'h1);
            check("hold_data", rsp_data, d);
        end
        @(posedge ACLK);
        #1;
        init_done = 1'b1;
        rsp_ready = 1'b1;
        @(posedge ACLK);
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int lat;
        int viol;
        bit ok;

        ARESET    = 1'b1;
        init_done = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        io_in     = 4'h0;
        mem[32'h100] = 8'h11;
        mem[32'h101] = 8'h22;
        mem[32'h102] = 8'h33;
        mem[32'h103] = 8'h44;
        repeat (3) @(posedge ACLK);
        #1;
        ARESET = 1'b0;

        // Requests refused while init is not done.
        req_valid = 1'b1;
        req_addr  = 24'h000100;
        viol = 0;
        repeat (50) begin
            @(negedge ACLK);
            if (req_ready !== 1'b0 || CS !== 1'b1 || CLOCK !== 1'b0) viol++;
        end
        check("init_low_refuse", 32'(viol), 32'h0);
        @(posedge ACLK);
        #1;
        req_valid = 1'b0;
        init_done = 1'b1;

        // Known data at 0x100, latency, pin decode, rsp_ready stall.
        read_word(24'h000100, 10, d, lat);
        check("data_0x100", d, 32'h44332211);
        check("latency", 32'(lat), 32'd97);
        check("pin_cmd", 32'(fl_cmd), 32'h6B);
        check("pin_addr", 32'(fl_addr), 32'h000100);
        check("pin_sclk_count", 32'(fl_total), 32'd48);

        // Reset in the middle of a read.
        req_addr  = 24'h000200;
        req_valid = 1'b1;
        wait_accept(ok);
        req_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge ACLK);
            #1;
            if (fl_rises >= 20) begin
                ok = 1;
                break;
            end
        end
        if (!ok) expire("sclk20");
        check("mid_read_cs", 32'(CS), 32'h0);
        ARESET = 1'b1;
        #1;
        check("async_reset_pins", 32'({CS, CLOCK, io_oe}), 32'({1'b1, 1'b0, 4'b1100}));
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;

        read_word(24'h7FFFFC, 0, d, lat);
        check("data_0x7ffffc", d, 32'h5A5B5859);
        check("pin_addr_7ffffc", 32'(fl_addr), 32'h7FFFFC);

        // Word straddling the top of the address space wraps to 0.
        read_word(24'hFFFFFE, 0, d, lat);
        check("data_wrap", d, 32'h5B5A5A5B);

        // Back-to-back with req_valid held and rsp_ready high.
        got_q.delete();
        rsp_ready = 1'b1;
        req_addr  = 24'h000000;
        req_valid = 1'b1;
        wait_accept(ok);
        req_addr = 24'h000004;
        wait_accept(ok);
        req_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge ACLK);
            #1;
            if (got_q.size() >= 2) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            expire("b2b_responses");
        end else begin
            check("b2b_word0", got_q[0], 32'h59585B5A);
            check("b2b_word1", got_q[1], 32'h5D5C5F5E);
        end
        check("b2b_gap", 32'(last_gap), 32'd5);
        check("cs_gap_min", 32'(min_gap >= CS_HIGH_MIN), 32'h1);
        rsp_ready = 1'b0;
        repeat (5) @(posedge ACLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
